// File: rtl/csa_accumulator.sv
// Frame accumulator: carry-save adds one operand per beat, then resolves S+C CHUNK bits per cycle.
// Optional sticky overflow flag is compiled in with `define CSA_ACC_OVERFLOW_EN.
module csa_accumulator #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 16,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_overflow
);

  localparam int N     = ACC_W / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESOLVE = 2'd1,
    OUTPUT  = 2'd2
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [ACC_W-1:0]   s_r;
  logic [ACC_W-1:0]   c_r;
  logic               carry_r;
  logic [IDX_W-1:0]   idx_r;
  logic [ACC_W-1:0]   res_r;
  logic [ACC_W-1:0]   sum_r;
  logic               valid_r;
  logic               ready_r;

  logic [ACC_W-1:0]   d_s;
  logic [ACC_W-1:0]   maj_s;
  logic [ACC_W-1:0]   csa_sum_s;
  logic [ACC_W-1:0]   csa_carry_s;
  logic [CHUNK:0]     slice_sum_s;
  logic [ACC_W-1:0]   res_next_s;
  logic               last_slice_s;

`ifdef CSA_ACC_OVERFLOW_EN
  logic               ovf_r;
  logic               overflow_r;
`endif

  assign o_ready = ready_r;
  assign o_valid = valid_r;
  assign o_sum   = sum_r;
`ifdef CSA_ACC_OVERFLOW_EN
  assign o_overflow = overflow_r;
`else
  assign o_overflow = 1'b0;
`endif

  // Carry-save step for the incoming beat and one ripple slice of the resolve phase
  always_comb begin
    d_s          = ACC_W'(i_data);
    maj_s        = (s_r & c_r) | (s_r & d_s) | (c_r & d_s);
    csa_sum_s    = s_r ^ c_r ^ d_s;
    csa_carry_s  = maj_s << 1;
    slice_sum_s  = (CHUNK+1)'(s_r[idx_r*CHUNK +: CHUNK])
                 + (CHUNK+1)'(c_r[idx_r*CHUNK +: CHUNK])
                 + (CHUNK+1)'(carry_r);
    res_next_s   = res_r;
    res_next_s[idx_r*CHUNK +: CHUNK] = slice_sum_s[CHUNK-1:0];
    last_slice_s = (idx_r == IDX_W'(N-1));
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_valid && i_last) next_state_s = RESOLVE;
        else                   next_state_s = IDLE;
      end
      RESOLVE: begin
        if (last_slice_s) next_state_s = OUTPUT;
        else              next_state_s = RESOLVE;
      end
      OUTPUT: begin
        if (i_ready) next_state_s = IDLE;
        else         next_state_s = OUTPUT;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      valid_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s == IDLE);
      valid_r <= (next_state_s == OUTPUT);
    end
  end

  // Datapath: CSA accumulation in IDLE, slice resolve, clear on result handshake
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s_r        <= '0;
      c_r        <= '0;
      carry_r    <= 1'b0;
      idx_r      <= '0;
      res_r      <= '0;
      sum_r      <= '0;
`ifdef CSA_ACC_OVERFLOW_EN
      ovf_r      <= 1'b0;
      overflow_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (i_valid) begin
            s_r   <= csa_sum_s;
            c_r   <= csa_carry_s;
            idx_r <= '0;
`ifdef CSA_ACC_OVERFLOW_EN
            ovf_r <= ovf_r | maj_s[ACC_W-1];
`endif
          end
        end
        RESOLVE: begin
          res_r   <= res_next_s;
          carry_r <= slice_sum_s[CHUNK];
          idx_r   <= idx_r + IDX_W'(1);
          if (last_slice_s) begin
            sum_r      <= res_next_s;
`ifdef CSA_ACC_OVERFLOW_EN
            // The final slice carry is the last weight-2^ACC_W term of the true sum
            overflow_r <= ovf_r | slice_sum_s[CHUNK];
`endif
          end
        end
        OUTPUT: begin
          if (i_ready) begin
            s_r     <= '0;
            c_r     <= '0;
            carry_r <= 1'b0;
            idx_r   <= '0;
`ifdef CSA_ACC_OVERFLOW_EN
            ovf_r   <= 1'b0;
`endif
          end
        end
        default: begin
          s_r     <= '0;
          c_r     <= '0;
          carry_r <= 1'b0;
          idx_r   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accumulator.sv
// Randomized self-checking bench for csa_accumulator; reference is a plain integer frame sum.
module tb_csa_accumulator;

  localparam int WIDTH = 8;
  localparam int ACC_W = 16;
  localparam int CHUNK = 4;
  localparam int N     = ACC_W / CHUNK;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic             i_last;
  logic             o_valid;
  logic             i_ready;
  logic [ACC_W-1:0] o_sum;
  logic             o_overflow;

  int n_checks = 0;
  int n_fails  = 0;
  int unsigned frame_q[$];

  csa_accumulator #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CHUNK(CHUNK)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .i_last     (i_last),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_sum      (o_sum),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sends frame_q, waits for the result, holds it for 'hold' cycles, then takes it.
  task automatic run_frame(input int gap, input int hold);
    longint unsigned total;
    logic [ACC_W-1:0] exp_sum;
    logic             exp_ovf;
    int               lat;
    int               ng;
    total = 0;
    for (int i = 0; i < frame_q.size(); i++) begin
      total += longint'(frame_q[i]);
      check_value("ready_idle", {63'd0, o_ready}, 64'd1);
      i_valid = 1'b1;
      i_data  = WIDTH'(frame_q[i]);
      i_last  = (i == frame_q.size() - 1);
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      i_last  = 1'b0;
      if (i != frame_q.size() - 1) begin
        ng = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        for (int g = 0; g < ng; g++) begin
          i_data = WIDTH'($urandom);
          @(negedge i_clk);
        end
      end
    end
    exp_sum = ACC_W'(total);
`ifdef CSA_ACC_OVERFLOW_EN
    exp_ovf = (total >= (64'd1 << ACC_W));
`else
    exp_ovf = 1'b0;
`endif
    lat = 0;
    while (o_valid !== 1'b1 && lat < 40) begin
      i_valid = 1'($urandom_range(0, 1));
      i_data  = WIDTH'($urandom);
      i_last  = 1'($urandom_range(0, 1));
      @(posedge i_clk);
      @(negedge i_clk);
      lat++;
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    check_value("latency", 64'(lat), 64'(N));
    check_value("sum", 64'(o_sum), 64'(exp_sum));
    check_value("overflow", {63'd0, o_overflow}, {63'd0, exp_ovf});
    i_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_data  = WIDTH'($urandom);
      i_last  = 1'($urandom_range(0, 1));
      @(posedge i_clk);
      @(negedge i_clk);
      check_value("hold_valid", {63'd0, o_valid}, 64'd1);
      check_value("hold_sum", 64'(o_sum), 64'(exp_sum));
      check_value("hold_ready", {63'd0, o_ready}, 64'd0);
    end
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ready = 1'b0;
    check_value("post_valid", {63'd0, o_valid}, 64'd0);
    check_value("post_ready", {63'd0, o_ready}, 64'd1);
    check_value("post_sum", 64'(o_sum), 64'(exp_sum));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_ready = 1'b0;
    repeat (3) @(negedge i_clk);
    check_value("rst_ready", {63'd0, o_ready}, 64'd1);
    check_value("rst_valid", {63'd0, o_valid}, 64'd0);
    check_value("rst_sum", 64'(o_sum), 64'd0);
    check_value("rst_ovf", {63'd0, o_overflow}, 64'd0);
    i_rst_n = 1'b1;

    frame_q = '{3, 5, 7};
    run_frame(-1, 2);

    frame_q = {};
    for (int i = 0; i < 257; i++) frame_q.push_back(255);
    run_frame(0, 1);
    check_value("sum_257_ff", 64'(o_sum), 64'h0000_0000_0000_FFFF);

    frame_q.push_back(255);
    run_frame(0, 0);
    check_value("sum_258_ff", 64'(o_sum), 64'h0000_0000_0000_00FE);

    frame_q = '{16, 32};
    run_frame(3, 10);
    frame_q = '{255};
    run_frame(0, 0);

    // Reset while resolving: no result, outputs cleared at once
    check_value("ready_pre_rst", {63'd0, o_ready}, 64'd1);
    i_valid = 1'b1;
    i_data  = 8'd5;
    i_last  = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check_value("midrst_ready", {63'd0, o_ready}, 64'd1);
    check_value("midrst_valid", {63'd0, o_valid}, 64'd0);
    check_value("midrst_sum", 64'(o_sum), 64'd0);
    check_value("midrst_ovf", {63'd0, o_overflow}, 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    frame_q = '{1};
    run_frame(0, 0);

    for (int f = 0; f < 20; f++) begin
      frame_q = {};
      for (int b = 0; b < int'($urandom_range(1, 6)); b++) frame_q.push_back($urandom_range(0, 255));
      run_frame(-1, int'($urandom_range(0, 3)));
    end

    for (int f = 0; f < 3; f++) begin
      frame_q = {};
      for (int b = 0; b < int'($urandom_range(260, 300)); b++) frame_q.push_back($urandom_range(128, 255));
      run_frame(0, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
